// File: rtl/spi_accel_responder.sv
// SPI mode-0 register responder for a 3-axis accelerometer sample set.
// Define SPI_RESP_WRITE_EN to enable the write command and power_ctl storage.

module spi_accel_responder (
    input  logic        ClkPort,
    input  logic        Reset,
    input  logic        sclk,
    input  logic        ss,
    input  logic        mosi,
    output logic        miso,
    output logic        miso_oe,
    input  logic [11:0] accel_x,
    input  logic [11:0] accel_y,
    input  logic [11:0] accel_z,
    input  logic        sample_valid,
    output logic [7:0]  power_ctl,
    output logic        wr_strobe,
    output logic [5:0]  wr_addr,
    output logic [7:0]  wr_data
);

`ifdef SPI_RESP_WRITE_EN
    localparam logic WR_EN = 1'b1;
`else
    localparam logic WR_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_RD,
        S_WR,
        S_IGN
    } state_t;

    state_t state, state_nx;

    logic [2:0]  sclk_sr;
    logic [2:0]  ss_sr;
    logic [2:0]  vld_sr;
    logic [1:0]  mosi_sr;
    logic        ss_q;
    logic        sclk_rise;
    logic        sclk_fall;
    logic        ss_fall;
    logic        byte_done;
    logic [2:0]  bit_cnt;
    logic [6:0]  rx_sr;
    logic [7:0]  rx_byte;
    logic        is_wr;
    logic [5:0]  ptr;
    logic [7:0]  tx_sr;
    logic        miso_r;
    logic        wr_strobe_r;
    logic [5:0]  wr_addr_r;
    logic [7:0]  wr_data_r;
    logic [7:0]  power_r;
    logic        soft_rst;
    logic [11:0] sh_x, sh_y, sh_z;
    logic [11:0] pd_x, pd_y, pd_z;
    logic        pend;

    // vld_sr marks when ss_sr holds real pin history, so a select held
    // low across Reset is not mistaken for a fresh falling edge.
    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            sclk_sr <= '0;
            ss_sr   <= '1;
            vld_sr  <= '0;
            mosi_sr <= '0;
        end else begin
            sclk_sr <= {sclk_sr[1:0], sclk};
            ss_sr   <= {ss_sr[1:0], ss};
            vld_sr  <= {vld_sr[1:0], 1'b1};
            mosi_sr <= {mosi_sr[0], mosi};
        end
    end

    assign ss_q      = ss_sr[1];
    assign sclk_rise = sclk_sr[1] & ~sclk_sr[2];
    assign sclk_fall = ~sclk_sr[1] & sclk_sr[2];
    assign ss_fall   = vld_sr[2] & ss_sr[2] & ~ss_sr[1];
    assign rx_byte   = {rx_sr, mosi_sr[1]};
    assign byte_done = sclk_rise & ~ss_q & (bit_cnt == 3'd7);
    assign soft_rst  = wr_strobe_r & (wr_addr_r == 6'h1F)
                     & (wr_data_r == 8'h52);

    function automatic logic [7:0] rd_byte(input logic [5:0] a);
        case (a)
            6'h00:   rd_byte = 8'hAD;
            6'h01:   rd_byte = 8'h1D;
            6'h02:   rd_byte = 8'hF2;
            6'h0E:   rd_byte = sh_x[7:0];
            6'h0F:   rd_byte = {{4{sh_x[11]}}, sh_x[11:8]};
            6'h10:   rd_byte = sh_y[7:0];
            6'h11:   rd_byte = {{4{sh_y[11]}}, sh_y[11:8]};
            6'h12:   rd_byte = sh_z[7:0];
            6'h13:   rd_byte = {{4{sh_z[11]}}, sh_z[11:8]};
            6'h2D:   rd_byte = power_r;
            default: rd_byte = 8'h00;
        endcase
    endfunction

    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (ss_fall) state_nx = S_CMD;
            end
            S_CMD: begin
                if (byte_done) begin
                    if (rx_byte == 8'h0B || (WR_EN && rx_byte == 8'h0A))
                        state_nx = S_ADDR;
                    else
                        state_nx = S_IGN;
                end
            end
            S_ADDR: begin
                if (byte_done) state_nx = is_wr ? S_WR : S_RD;
            end
            default: state_nx = state;
        endcase
        if (ss_q) state_nx = S_IDLE;
    end

    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            bit_cnt     <= '0;
            rx_sr       <= '0;
            is_wr       <= 1'b0;
            ptr         <= '0;
            tx_sr       <= '0;
            miso_r      <= 1'b0;
            wr_strobe_r <= 1'b0;
            wr_addr_r   <= '0;
            wr_data_r   <= '0;
            power_r     <= '0;
        end else begin
            wr_strobe_r <= 1'b0;
            if (state == S_IDLE) bit_cnt <= '0;
            else if (sclk_rise) bit_cnt <= bit_cnt + 3'd1;
            if (sclk_rise) rx_sr <= rx_byte[6:0];
            if (state == S_CMD && byte_done) is_wr <= (rx_byte == 8'h0A);
            if (state == S_ADDR && byte_done) begin
                ptr    <= rx_byte[5:0];
                tx_sr  <= rd_byte(rx_byte[5:0]);
                miso_r <= 1'b0;
            end
            if (state == S_RD) begin
                if (sclk_fall) begin
                    miso_r <= tx_sr[7];
                    tx_sr  <= {tx_sr[6:0], 1'b0};
                end
                if (byte_done) begin
                    ptr   <= ptr + 6'd1;
                    tx_sr <= rd_byte(ptr + 6'd1);
                end
            end
            if (WR_EN && state == S_WR && byte_done) begin
                wr_strobe_r <= 1'b1;
                wr_addr_r   <= ptr;
                wr_data_r   <= rx_byte;
                ptr         <= ptr + 6'd1;
                if (ptr == 6'h2D) power_r <= rx_byte;
            end
            if (soft_rst) power_r <= '0;
        end
    end

    // Samples arriving mid-burst are parked so a burst reads one sample.
    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            sh_x <= '0;
            sh_y <= '0;
            sh_z <= '0;
            pd_x <= '0;
            pd_y <= '0;
            pd_z <= '0;
            pend <= 1'b0;
        end else begin
            if (ss_q) begin
                if (sample_valid) begin
                    sh_x <= accel_x;
                    sh_y <= accel_y;
                    sh_z <= accel_z;
                end else if (pend) begin
                    sh_x <= pd_x;
                    sh_y <= pd_y;
                    sh_z <= pd_z;
                end
                pend <= 1'b0;
            end else if (sample_valid) begin
                pd_x <= accel_x;
                pd_y <= accel_y;
                pd_z <= accel_z;
                pend <= 1'b1;
            end
            if (soft_rst) begin
                sh_x <= '0;
                sh_y <= '0;
                sh_z <= '0;
            end
        end
    end

    assign miso      = (state == S_RD) & miso_r;
    assign miso_oe   = ~ss_q;
    assign wr_strobe = wr_strobe_r;
    assign wr_addr   = wr_addr_r;
    assign wr_data   = wr_data_r;
    assign power_ctl = WR_EN ? power_r : 8'h00;

endmodule

// File: tb/tb_spi_accel_responder.sv
// Randomized self-checking bench for spi_accel_responder with a register-map model.
// Expectations follow SPI_RESP_WRITE_EN when it is defined for the build.

module tb_spi_accel_responder;

`ifdef SPI_RESP_WRITE_EN
    localparam bit WEN = 1'b1;
`else
    localparam bit WEN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        Reset = 1'b1;
    logic        sclk = 1'b0;
    logic        ss = 1'b1;
    logic        mosi = 1'b0;
    logic [11:0] accel_x = '0;
    logic [11:0] accel_y = '0;
    logic [11:0] accel_z = '0;
    logic        sample_valid = 1'b0;
    logic        miso;
    logic        miso_oe;
    logic [7:0]  power_ctl;
    logic        wr_strobe;
    logic [5:0]  wr_addr;
    logic [7:0]  wr_data;

    spi_accel_responder dut (
        .ClkPort(clk),
        .Reset(Reset),
        .sclk(sclk),
        .ss(ss),
        .mosi(mosi),
        .miso(miso),
        .miso_oe(miso_oe),
        .accel_x(accel_x),
        .accel_y(accel_y),
        .accel_z(accel_z),
        .sample_valid(sample_valid),
        .power_ctl(power_ctl),
        .wr_strobe(wr_strobe),
        .wr_addr(wr_addr),
        .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int nstr = 0;

    always @(negedge clk) if (wr_strobe === 1'b1) nstr++;

    // Reference model state
    logic [11:0] mx = '0, my = '0, mz = '0;
    logic [11:0] px = '0, py = '0, pz = '0;
    logic        mpend = 1'b0;
    logic [7:0]  mpow = '0;
    logic [5:0]  mwa = '0;
    logic [7:0]  mwd = '0;

    logic [7:0]  txb [0:15];
    logic [7:0]  rxb [0:15];
    logic        oe_ok;

    function automatic int sval(input logic [11:0] r);
        int v = int'(r);
        if (v >= 2048) v -= 4096;
        return v;
    endfunction

    function automatic logic [7:0] mreg(input int a);
        int v = 0;
        case (a)
            'h00: return 8'hAD;
            'h01: return 8'h1D;
            'h02: return 8'hF2;
            'h0E, 'h0F: v = sval(mx);
            'h10, 'h11: v = sval(my);
            'h12, 'h13: v = sval(mz);
            'h2D: return mpow;
            default: return 8'h00;
        endcase
        if (a % 2 == 1) v = v >>> 8;
        return 8'(v & 255);
    endfunction

    task automatic model_write(input int a, input logic [7:0] d);
        mwa = 6'(a);
        mwd = d;
        if (a == 'h2D) mpow = d;
        if (a == 'h1F && d == 8'h52) begin
            mpow = 0; mx = 0; my = 0; mz = 0;
        end
    endtask

    task automatic model_reset();
        mx = 0; my = 0; mz = 0; mpend = 0;
        mpow = 0; mwa = 0; mwd = 0;
    endtask

    task automatic pulse_sample(input logic [11:0] x, y, z);
        @(negedge clk);
        accel_x = x; accel_y = y; accel_z = z;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        if (ss) begin
            mx = x; my = y; mz = z;
        end else begin
            px = x; py = y; pz = z; mpend = 1'b1;
        end
    endtask

    task automatic spi_bits(input logic [7:0] v, input int nb,
                            output logic [7:0] r);
        r = '0;
        for (int i = 0; i < nb; i++) begin
            mosi = v[7-i];
            #80;
            r[7-i] = miso;
            if (miso_oe !== 1'b1) oe_ok = 1'b0;
            sclk = 1'b1;
            #80;
            sclk = 1'b0;
        end
    endtask

    task automatic end_txn();
        #80 ss = 1'b1;
        mosi = 1'b0;
        #160;
        if (mpend) begin
            mx = px; my = py; mz = pz; mpend = 1'b0;
        end
        total++;
        if (miso_oe !== 1'b0) begin
            bad++;
            $display("FAIL oe_idle: got=%b want=0", miso_oe);
        end
    endtask

    task automatic spi_txn(input int n);
        oe_ok = 1'b1;
        ss = 1'b0;
        #80;
        for (int b = 0; b < n; b++) spi_bits(txb[b], 8, rxb[b]);
        total++;
        if (oe_ok !== 1'b1) begin
            bad++;
            $display("FAIL oe_selected: got=0 want=1");
        end
        end_txn();
    endtask

    task automatic check_read(input logic [5:0] a, input int n,
                              input string tag);
        logic [7:0] e;
        txb[0] = 8'h0B;
        txb[1] = {2'($urandom), a};
        for (int k = 0; k < n; k++) txb[k+2] = 8'($urandom);
        spi_txn(n + 2);
        total++;
        if ({rxb[0], rxb[1]} !== 16'h0) begin
            bad++;
            $display("FAIL %s_hdr: got=%h%h want=0000", tag, rxb[0], rxb[1]);
        end
        for (int k = 0; k < n; k++) begin
            e = mreg((int'(a) + k) % 64);
            total++;
            if (rxb[k+2] !== e) begin
                bad++;
                $display("FAIL %s[%0h+%0d]: got=%h want=%h",
                         tag, a, k, rxb[k+2], e);
            end
        end
    endtask

    task automatic do_write(input logic [5:0] a, input int n,
                            input logic [7:0] d0);
        int s0 = nstr;
        int en = WEN ? n : 0;
        txb[0] = 8'h0A;
        txb[1] = {2'b00, a};
        txb[2] = d0;
        for (int k = 1; k < n; k++) txb[k+2] = 8'($urandom);
        spi_txn(n + 2);
        if (WEN)
            for (int k = 0; k < n; k++)
                model_write((int'(a) + k) % 64, txb[k+2]);
        total++;
        if (nstr - s0 !== en) begin
            bad++;
            $display("FAIL wr_count: got=%0d want=%0d", nstr - s0, en);
        end
        total++;
        if ({wr_addr, wr_data} !== {mwa, mwd}) begin
            bad++;
            $display("FAIL wr_addr_data: got=%h/%h want=%h/%h",
                     wr_addr, wr_data, mwa, mwd);
        end
        total++;
        if (power_ctl !== mpow) begin
            bad++;
            $display("FAIL power_ctl: got=%h want=%h", power_ctl, mpow);
        end
    endtask

    task automatic test_reset();
        #40;
        total++;
        if (miso !== 1'b0) begin bad++; $display("FAIL rst_miso: got=%b want=0", miso); end
        total++;
        if (miso_oe !== 1'b0) begin bad++; $display("FAIL rst_oe: got=%b want=0", miso_oe); end
        total++;
        if (wr_strobe !== 1'b0) begin bad++; $display("FAIL rst_strobe: got=%b want=0", wr_strobe); end
        total++;
        if (power_ctl !== 8'h00) begin bad++; $display("FAIL rst_power: got=%h want=00", power_ctl); end
        total++;
        if ({wr_addr, wr_data} !== 14'h0) begin
            bad++;
            $display("FAIL rst_wr: got=%h/%h want=0/0", wr_addr, wr_data);
        end
        Reset = 1'b0;
        #80;
    endtask

    task automatic test_id_read();
        check_read(6'h00, 3, "id");
    endtask

    task automatic test_axis();
        pulse_sample(12'($urandom), 12'hF83, 12'($urandom));
        check_read(6'h10, 2, "axis_y");
        for (int i = 0; i < 5; i++) begin
            pulse_sample(12'($urandom), 12'($urandom), 12'($urandom));
            check_read(6'h0E, 6, "axis_all");
        end
    endtask

    task automatic test_coherent();
        logic [7:0] r0, r1, e0, e1;
        e0 = mreg('h0E);
        e1 = mreg('h0F);
        oe_ok = 1'b1;
        ss = 1'b0;
        #80;
        spi_bits(8'h0B, 8, r0);
        spi_bits(8'h0E, 8, r0);
        spi_bits(8'h00, 8, r0);
        pulse_sample(12'($urandom), 12'($urandom), 12'($urandom));
        pulse_sample(12'h123, 12'($urandom), 12'($urandom));
        spi_bits(8'h00, 8, r1);
        total++;
        if ({r0, r1} !== {e0, e1}) begin
            bad++;
            $display("FAIL coherent: got=%h %h want=%h %h", r0, r1, e0, e1);
        end
        end_txn();
        check_read(6'h0E, 6, "after_pend");
    endtask

    task automatic test_write();
        do_write(6'h2D, 1, 8'h02);
        check_read(6'h2D, 1, "pwr_rd");
        for (int i = 0; i < 3; i++)
            do_write(6'($urandom), 3, 8'($urandom));
        do_write(6'h00, 1, 8'h5A);
        check_read(6'h00, 3, "ro_id");
        pulse_sample(12'($urandom), 12'($urandom), 12'($urandom));
        do_write(6'h2D, 1, 8'h08);
        do_write(6'h1F, 1, 8'h52);
        check_read(6'h0E, 6, "softrst");
        check_read(6'h2D, 1, "softrst_pwr");
    endtask

    task automatic test_wrap();
        check_read(6'h3F, 2, "wrap");
        for (int i = 0; i < 5; i++)
            check_read(6'($urandom), 3, "rand_rd");
    endtask

    task automatic test_ignore();
        logic [7:0] c;
        int s0;
        for (int i = 0; i < 4; i++) begin
            c = 8'h55;
            if (i > 0)
                do c = 8'($urandom); while (c == 8'h0A || c == 8'h0B);
            txb[0] = c;
            txb[1] = 8'h00;
            txb[2] = 8'h0B;
            txb[3] = 8'h00;
            s0 = nstr;
            spi_txn(4);
            total++;
            if ({rxb[0], rxb[1], rxb[2], rxb[3]} !== 32'h0 || nstr != s0) begin
                bad++;
                $display("FAIL ignore_%h: got=%h%h%h%h strobes=%0d want=0",
                         c, rxb[0], rxb[1], rxb[2], rxb[3], nstr - s0);
            end
        end
    endtask

    task automatic test_partial();
        logic [7:0] r;
        int s0 = nstr;
        oe_ok = 1'b1;
        ss = 1'b0;
        #80;
        spi_bits(8'h0A, 8, r);
        spi_bits(8'h2D, 8, r);
        spi_bits(8'hA5, 5, r);
        end_txn();
        total++;
        if (nstr != s0 || power_ctl !== mpow) begin
            bad++;
            $display("FAIL partial_wr: got=%0d/%h want=0/%h",
                     nstr - s0, power_ctl, mpow);
        end
        oe_ok = 1'b1;
        ss = 1'b0;
        #80;
        spi_bits(8'h0B, 8, r);
        spi_bits(8'h01, 8, r);
        spi_bits(8'h00, 3, r);
        end_txn();
        check_read(6'h01, 2, "after_partial");
    endtask

    task automatic test_reset_mid();
        logic [7:0] r;
        pulse_sample(12'($urandom_range(1, 4095)), 12'($urandom), 12'($urandom));
        oe_ok = 1'b1;
        ss = 1'b0;
        #80;
        spi_bits(8'h0B, 8, r);
        spi_bits(8'h00, 3, r);
        mosi = 1'b0;
        #80;
        sclk = 1'b1;
        #40;
        Reset = 1'b1;
        model_reset();
        #1;
        total++;
        if ({miso, miso_oe, wr_strobe} !== 3'b000) begin
            bad++;
            $display("FAIL midrst_out: got=%b%b%b want=000", miso, miso_oe, wr_strobe);
        end
        total++;
        if ({power_ctl, wr_addr, wr_data} !== 22'h0) begin
            bad++;
            $display("FAIL midrst_regs: got=%h/%h/%h want=0", power_ctl, wr_addr, wr_data);
        end
        #39;
        sclk = 1'b0;
        #40;
        Reset = 1'b0;
        #80;
        spi_bits(8'h00, 4, r);
        txb[0] = 8'h0B; txb[1] = 8'h00; txb[2] = 8'h00; txb[3] = 8'h00;
        for (int b = 0; b < 4; b++) begin
            spi_bits(txb[b], 8, r);
            total++;
            if (r !== 8'h00) begin
                bad++;
                $display("FAIL midrst_idle[%0d]: got=%h want=00", b, r);
            end
        end
        end_txn();
        check_read(6'h00, 3, "midrst_id");
        check_read(6'h0E, 6, "midrst_shadow");
    endtask

    initial begin
        test_reset();
        test_id_read();
        test_axis();
        test_coherent();
        test_write();
        test_wrap();
        test_ignore();
        test_partial();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
